// File: rtl/mips_cpu_mem_arbiter.sv
// Two-requester memory arbiter: shares one combinational-read /
// single-cycle-write memory port between instruction fetch and data access.
// Grants are combinational from the requests; read data and the response
// valids are registered, so responses appear one cycle after the grant.
module mips_cpu_mem_arbiter #(
    parameter int POLICY   = 1,  // 0: round-robin on conflict, 1: data priority + fetch starvation guard
    parameter int MAX_WAIT = 3   // denied fetch cycles before fetch is forced (POLICY=1), 1..15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    gnt_e        last_gnt_q, last_gnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        i_rvalid_q, d_rvalid_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        grant_i, grant_d;

    // Arbitration; grants are gated by reset so nothing reaches memory while in reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (reset_n) begin
            if (i_req && d_req) begin
                if (POLICY == 0) begin
                    // Alternate: serve whoever did not win last time.
                    if (last_gnt_q == GNT_DATA) grant_i = 1'b1;
                    else                        grant_d = 1'b1;
                end else begin
                    // Data wins unless fetch has waited MAX_WAIT cycles in a row.
                    if (starve_cnt_q == MAX_WAIT_C) grant_i = 1'b1;
                    else                            grant_d = 1'b1;
                end
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // Next-state for the last-grant tracker and the fetch starvation counter.
    always_comb begin
        last_gnt_d   = last_gnt_q;
        starve_cnt_d = starve_cnt_q;
        if (grant_i)      last_gnt_d = GNT_INSTR;
        else if (grant_d) last_gnt_d = GNT_DATA;

        if (!i_req || grant_i)             starve_cnt_d = 4'd0;
        else if (starve_cnt_q < MAX_WAIT_C) starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Memory port drive; all zeros when nobody is granted.
    always_comb begin
        mem_address   = 32'd0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = 32'd0;
        if (grant_i) begin
            mem_address = i_addr;
            mem_read    = 1'b1;
        end else if (grant_d) begin
            mem_address = d_addr;
            if (d_we) begin
                mem_write     = 1'b1;
                mem_writedata = d_wdata;
            end else begin
                mem_read = 1'b1;
            end
        end
    end

    // State and response registers; rdata only moves on a read grant to its owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q   <= GNT_INSTR;
            starve_cnt_q <= 4'd0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            starve_cnt_q <= starve_cnt_d;
            i_rvalid_q   <= grant_i;
            d_rvalid_q   <= grant_d;
            if (grant_i)          i_rdata_q <= mem_readdata;
            if (grant_d && !d_we) d_rdata_q <= mem_readdata;
        end
    end

    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Bench for mips_cpu_mem_arbiter: one round-robin instance and one
// data-priority instance, each with its own memory, driven by directed and
// random requests and checked against a transaction-level reference model.
module tb_mips_cpu_mem_arbiter;
    localparam int MAXW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_init;
    logic        ir[2], dr[2], dwe[2];
    logic [31:0] ia[2], da[2], dwd[2];
    logic        igt[2], dgt[2], irv[2], drv[2], mrd[2], mwr[2];
    logic [31:0] ird[2], drd[2], maddr[2], mwd[2], mrdat[2];
    logic [31:0] mem [2][256];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit          last_d[2];
    int          starve[2];
    bit          e_irv[2], e_drv[2];
    logic [31:0] e_ird[2], e_drd[2];
    logic [31:0] ref_mem [2][256];
    bit          gi_l[2], gd_l[2];

    mips_cpu_mem_arbiter #(.POLICY(0), .MAX_WAIT(MAXW)) u_rr (
        .clk(clk), .reset_n(rst_n),
        .i_req(ir[0]), .i_addr(ia[0]), .i_gnt(igt[0]), .i_rvalid(irv[0]), .i_rdata(ird[0]),
        .d_req(dr[0]), .d_we(dwe[0]), .d_addr(da[0]), .d_wdata(dwd[0]),
        .d_gnt(dgt[0]), .d_rvalid(drv[0]), .d_rdata(drd[0]),
        .mem_address(maddr[0]), .mem_read(mrd[0]), .mem_write(mwr[0]),
        .mem_writedata(mwd[0]), .mem_readdata(mrdat[0]));

    mips_cpu_mem_arbiter #(.POLICY(1), .MAX_WAIT(MAXW)) u_dp (
        .clk(clk), .reset_n(rst_n),
        .i_req(ir[1]), .i_addr(ia[1]), .i_gnt(igt[1]), .i_rvalid(irv[1]), .i_rdata(ird[1]),
        .d_req(dr[1]), .d_we(dwe[1]), .d_addr(da[1]), .d_wdata(dwd[1]),
        .d_gnt(dgt[1]), .d_rvalid(drv[1]), .d_rdata(drd[1]),
        .mem_address(maddr[1]), .mem_read(mrd[1]), .mem_write(mwr[1]),
        .mem_writedata(mwd[1]), .mem_readdata(mrdat[1]));

    function automatic logic [31:0] init_val(input int idx);
        if (idx == 0) return 32'h2402_0005;
        return (32'(idx) * 32'h0101_0101) ^ 32'hA5A5_5A5A;
    endfunction

    // memories: combinational read, write commits at posedge
    assign mrdat[0] = mem[0][maddr[0][9:2]];
    assign mrdat[1] = mem[1][maddr[1][9:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 256; i++) mem[k][i] <= init_val(i);
        end else begin
            for (int k = 0; k < 2; k++)
                if (mwr[k]) mem[k][maddr[k][9:2]] <= mwd[k];
        end
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // who should be granted, from the arbitration rules
    task automatic ref_grant(input int k, output bit gi, output bit gd);
        gi = 1'b0;
        gd = 1'b0;
        if (rst_n) begin
            if (ir[k] && dr[k]) begin
                if (k == 0) begin
                    if (last_d[k]) gi = 1'b1; else gd = 1'b1;
                end else begin
                    if (starve[k] == MAXW) gi = 1'b1; else gd = 1'b1;
                end
            end else begin
                gi = ir[k];
                gd = dr[k];
            end
        end
    endtask

    // one clock: check combinational side, advance model at posedge, check registers
    task automatic do_cycle();
        bit gi, gd;
        logic [31:0] ea;
        #1;
        for (int k = 0; k < 2; k++) begin
            ref_grant(k, gi, gd);
            gi_l[k] = gi;
            gd_l[k] = gd;
            ea = gi ? ia[k] : (gd ? da[k] : 32'd0);
            chk("i_gnt", k, 32'(igt[k]), 32'(gi));
            chk("d_gnt", k, 32'(dgt[k]), 32'(gd));
            chk("mem_read", k, 32'(mrd[k]), 32'(gi || (gd && !dwe[k])));
            chk("mem_write", k, 32'(mwr[k]), 32'(gd && dwe[k]));
            chk("mem_address", k, maddr[k], ea);
            if (gd && dwe[k])  chk("mem_writedata", k, mwd[k], dwd[k]);
            else if (!gi && !gd) chk("mem_writedata_idle", k, mwd[k], 32'd0);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                e_irv[k] = 0; e_drv[k] = 0; e_ird[k] = 0; e_drd[k] = 0;
                starve[k] = 0; last_d[k] = 0;
            end else begin
                e_irv[k] = gi_l[k];
                e_drv[k] = gd_l[k];
                if (gi_l[k]) e_ird[k] = ref_mem[k][ia[k][9:2]];
                if (gd_l[k]) begin
                    if (dwe[k]) ref_mem[k][da[k][9:2]] = dwd[k];
                    else        e_drd[k] = ref_mem[k][da[k][9:2]];
                end
                if (gi_l[k])      last_d[k] = 0;
                else if (gd_l[k]) last_d[k] = 1;
                if (!ir[k] || gi_l[k]) starve[k] = 0;
                else if (starve[k] < MAXW) starve[k]++;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("i_rvalid", k, 32'(irv[k]), 32'(e_irv[k]));
            chk("d_rvalid", k, 32'(drv[k]), 32'(e_drv[k]));
            chk("i_rdata", k, ird[k], e_ird[k]);
            chk("d_rdata", k, drd[k], e_drd[k]);
        end
        @(negedge clk);
    endtask

    // random requests honouring the hold-until-granted handshake
    task automatic rand_next();
        for (int k = 0; k < 2; k++) begin
            if (!(ir[k] && !gi_l[k])) begin
                ir[k] = ($urandom_range(0, 3) != 0);
                ia[k] = $urandom;
            end
            if (!(dr[k] && !gd_l[k])) begin
                dr[k]  = ($urandom_range(0, 2) != 0);
                dwe[k] = 1'($urandom_range(0, 1));
                da[k]  = ($urandom_range(0, 7) == 0) ? ia[k] : $urandom;
                dwd[k] = $urandom;
            end
        end
    endtask

    task automatic set_all(input bit i_r, input logic [31:0] i_a,
                           input bit d_r, input bit d_w, input logic [31:0] d_a, input logic [31:0] d_wd);
        for (int k = 0; k < 2; k++) begin
            ir[k] = i_r; ia[k] = i_a; dr[k] = d_r; dwe[k] = d_w; da[k] = d_a; dwd[k] = d_wd;
        end
    endtask

    logic [7:0] rr_tab, dp_tab;
    bit         done;

    initial begin
        rr_tab = 8'b1010_1010;   // D,I,D,I,... (bit c = fetch granted in cycle c)
        dp_tab = 8'b1000_1000;   // D,D,D,I,...
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) ref_mem[k][i] = init_val(i);
            last_d[k] = 0; starve[k] = 0; e_irv[k] = 0; e_drv[k] = 0;
            e_ird[k] = 0; e_drd[k] = 0; gi_l[k] = 0; gd_l[k] = 0;
        end

        // reset held with both requesting: everything must stay quiet
        rst_n    = 1'b0;
        mem_init = 1'b1;
        set_all(1, 32'hBFC0_0000, 1, 1, 32'h0000_0010, 32'h1111_1111);
        @(negedge clk);
        mem_init = 1'b0;
        do_cycle();
        do_cycle();

        // first fetch after reset
        rst_n = 1'b1;
        set_all(1, 32'hBFC0_0000, 0, 0, 32'd0, 32'd0);
        do_cycle();
        for (int k = 0; k < 2; k++) chk("boot_fetch", k, ird[k], 32'h2402_0005);

        // data write then read back
        set_all(0, 32'd0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF);
        do_cycle();
        set_all(0, 32'd0, 1, 0, 32'h0000_0010, 32'd0);
        do_cycle();
        for (int k = 0; k < 2; k++) chk("wr_rd_back", k, drd[k], 32'hDEAD_BEEF);

        // fresh reset, then continuous conflict: grant patterns per policy
        rst_n = 1'b0;
        set_all(0, 32'd0, 0, 0, 32'd0, 32'd0);
        do_cycle();
        rst_n = 1'b1;
        set_all(1, 32'h0000_0100, 1, 0, 32'h0000_0204, 32'd0);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_pattern", 0, 32'(igt[0]), 32'(rr_tab[c]));
            chk("dp_pattern", 1, 32'(igt[1]), 32'(dp_tab[c]));
            do_cycle();
        end

        // write and fetch to the same word: fetch must see the written value
        set_all(1, 32'h0000_0040, 1, 1, 32'h0000_0040, 32'h1234_5678);
        done = 0;
        for (int t = 0; t < 6 && !done; t++) begin
            do_cycle();
            for (int k = 0; k < 2; k++) begin
                if (gi_l[k]) ir[k] = 0;
                if (gd_l[k]) dr[k] = 0;
            end
            done = !ir[0] && !dr[0] && !ir[1] && !dr[1];
        end
        chk("wf_timeout", 0, 32'(done), 32'd1);
        for (int k = 0; k < 2; k++) chk("wf_fetch_sees_write", k, ird[k], 32'h1234_5678);

        // reset asserted during a write grant: no commit, no ack
        set_all(0, 32'd0, 1, 1, 32'h0000_0080, 32'hCAFE_F00D);
        rst_n = 1'b0;
        do_cycle();
        for (int k = 0; k < 2; k++) chk("rst_write_dropped", k, mem[k][32], init_val(32));
        rst_n = 1'b1;
        set_all(0, 32'd0, 0, 0, 32'd0, 32'd0);

        // load both rdata registers, then idle: values hold
        set_all(1, 32'h0000_0008, 1, 0, 32'h0000_000C, 32'd0);
        done = 0;
        for (int t = 0; t < 6 && !done; t++) begin
            do_cycle();
            for (int k = 0; k < 2; k++) begin
                if (gi_l[k]) ir[k] = 0;
                if (gd_l[k]) dr[k] = 0;
            end
            done = !ir[0] && !dr[0] && !ir[1] && !dr[1];
        end
        chk("load_timeout", 0, 32'(done), 32'd1);
        for (int c = 0; c < 3; c++) do_cycle();
        for (int k = 0; k < 2; k++) chk("idle_hold_i", k, ird[k], init_val(2));
        for (int k = 0; k < 2; k++) chk("idle_hold_d", k, drd[k], init_val(3));

        // random traffic with one reset in the middle
        for (int c = 0; c < 400; c++) begin
            rand_next();
            rst_n = (c != 200);
            do_cycle();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
